// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 4-requester round-robin mux arbiter.
package mux_arb_pkg;

    localparam int N_REQ  = 4;
    localparam int SEL_W  = 2;
    localparam int HCNT_W = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Next requester index in round-robin order (wraps 3 -> 0).
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
        return idx + 2'd1;
    endfunction

    // One-hot decode of a requester index.
    function automatic logic [N_REQ-1:0] idx_onehot(input logic [SEL_W-1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: searches req starting at ptr and wrapping,
// reporting whether anyone requests, the winner's index and its one-hot form.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx,
    output logic [N_REQ-1:0] win
);

    logic [SEL_W-1:0] cand_s;

    // Scan from the farthest offset down so the requester nearest ptr wins last.
    always_comb begin
        found  = 1'b0;
        idx    = ptr;
        win    = 4'b0000;
        cand_s = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand_s = ptr + SEL_W'(k);
            if (req[cand_s]) begin
                found = 1'b1;
                idx   = cand_s;
            end else begin
                found = found;
            end
        end
        if (found) begin
            win = idx_onehot(idx);
        end else begin
            win = 4'b0000;
        end
    end

endmodule

// File: rtl/mux_arb4.sv
// Round-robin arbiter and select sequencer for a shared 1-bit 4:1 mux path.
// One requester owns the path per tenure; a tenure ends when the owner drops
// its request or has held the path MAX_HOLD cycles, and hand-over happens on
// the same edge without a dead cycle.
module mux_arb4
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] din,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             dout,
    output logic             dout_vld,
    output logic             busy
);

    localparam logic [HCNT_W-1:0] HOLD_LIM = HCNT_W'(MAX_HOLD);
    localparam logic [HCNT_W-1:0] HCNT_SAT = {HCNT_W{1'b1}};

    state_t            state_r;
    logic [N_REQ-1:0]  gnt_r;
    logic [SEL_W-1:0]  sel_r;
    logic [SEL_W-1:0]  ptr_r;
    logic              vld_r;
    logic              busy_r;
    logic [HCNT_W-1:0] hcnt_r;

    logic [SEL_W-1:0]  pick_ptr_s;
    logic [SEL_W-1:0]  next_ptr_s;
    logic              pick_found_s;
    logic [SEL_W-1:0]  pick_idx_s;
    logic [N_REQ-1:0]  pick_win_s;
    logic              tenure_end_s;
    logic              dout_s;

    // Decide whether the current tenure ends and which pointer the picker uses;
    // at a tenure end the search already starts just past the outgoing owner.
    always_comb begin
        tenure_end_s = 1'b0;
        next_ptr_s   = next_idx(sel_r);
        pick_ptr_s   = ptr_r;
        if (state_r == GRANT) begin
            pick_ptr_s = next_ptr_s;
            if ((req[sel_r] == 1'b0) || (hcnt_r >= HOLD_LIM)) begin
                tenure_end_s = 1'b1;
            end else begin
                tenure_end_s = 1'b0;
            end
        end else begin
            pick_ptr_s   = ptr_r;
            tenure_end_s = 1'b0;
        end
    end

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (pick_ptr_s),
        .found (pick_found_s),
        .idx   (pick_idx_s),
        .win   (pick_win_s)
    );

    // Arbitration FSM with registered grant, select, valid and busy outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            gnt_r   <= 4'b0000;
            sel_r   <= 2'd0;
            vld_r   <= 1'b0;
            busy_r  <= 1'b0;
            ptr_r   <= 2'd0;
            hcnt_r  <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_found_s) begin
                        state_r <= GRANT;
                        gnt_r   <= pick_win_s;
                        sel_r   <= pick_idx_s;
                        vld_r   <= 1'b1;
                        busy_r  <= 1'b1;
                        hcnt_r  <= 8'd1;
                    end else begin
                        state_r <= IDLE;
                        gnt_r   <= 4'b0000;
                        vld_r   <= 1'b0;
                        busy_r  <= 1'b0;
                        hcnt_r  <= 8'd0;
                    end
                end
                GRANT: begin
                    if (tenure_end_s) begin
                        ptr_r <= next_ptr_s;
                        if (pick_found_s) begin
                            state_r <= GRANT;
                            gnt_r   <= pick_win_s;
                            sel_r   <= pick_idx_s;
                            vld_r   <= 1'b1;
                            busy_r  <= 1'b1;
                            hcnt_r  <= 8'd1;
                        end else begin
                            state_r <= IDLE;
                            gnt_r   <= 4'b0000;
                            vld_r   <= 1'b0;
                            busy_r  <= 1'b0;
                            hcnt_r  <= 8'd0;
                        end
                    end else if (hcnt_r != HCNT_SAT) begin
                        hcnt_r <= hcnt_r + 8'd1;
                    end else begin
                        hcnt_r <= hcnt_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    gnt_r   <= 4'b0000;
                    sel_r   <= 2'd0;
                    vld_r   <= 1'b0;
                    busy_r  <= 1'b0;
                    ptr_r   <= 2'd0;
                    hcnt_r  <= 8'd0;
                end
            endcase
        end
    end

    // Zero-latency 4:1 data mux, forced low whenever nobody holds the path.
    always_comb begin
        dout_s = 1'b0;
        if (vld_r) begin
            case (sel_r)
                2'd0:    dout_s = din[0];
                2'd1:    dout_s = din[1];
                2'd2:    dout_s = din[2];
                2'd3:    dout_s = din[3];
                default: dout_s = 1'b0;
            endcase
        end else begin
            dout_s = 1'b0;
        end
    end

    assign gnt      = gnt_r;
    assign sel      = sel_r;
    assign dout     = dout_s;
    assign dout_vld = vld_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_mux_arb4.sv
// Bench for mux_arb4: three instances (MAX_HOLD 8, 4, 2) driven from one
// vector table through a scoreboard, plus hand-written sub-cycle sequences.
module tb_mux_arb4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a  [3];
    logic [3:0] req_a  [3];
    logic [3:0] din_a  [3];
    logic [3:0] gnt_a  [3];
    logic [1:0] sel_a  [3];
    logic       dout_a [3];
    logic       vld_a  [3];
    logic       busy_a [3];

    mux_arb4 #(.MAX_HOLD(8)) dut8 (
        .clk(clk), .rst_n(rst_a[0]), .req(req_a[0]), .din(din_a[0]),
        .gnt(gnt_a[0]), .sel(sel_a[0]), .dout(dout_a[0]),
        .dout_vld(vld_a[0]), .busy(busy_a[0]));

    mux_arb4 #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst_n(rst_a[1]), .req(req_a[1]), .din(din_a[1]),
        .gnt(gnt_a[1]), .sel(sel_a[1]), .dout(dout_a[1]),
        .dout_vld(vld_a[1]), .busy(busy_a[1]));

    mux_arb4 #(.MAX_HOLD(2)) dut2 (
        .clk(clk), .rst_n(rst_a[2]), .req(req_a[2]), .din(din_a[2]),
        .gnt(gnt_a[2]), .sel(sel_a[2]), .dout(dout_a[2]),
        .dout_vld(vld_a[2]), .busy(busy_a[2]));

    typedef struct {
        int         inst;
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] din;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       vld;
        logic       busy;
        logic       dout;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input int inst, input logic r, input logic [3:0] rq,
                                input logic [3:0] d, input logic [3:0] g,
                                input logic [1:0] s, input logic o);
        vec_t v;
        v.inst  = inst;
        v.rst_n = r;
        v.req   = rq;
        v.din   = d;
        v.gnt   = g;
        v.sel   = s;
        v.vld   = (g != 4'b0000);
        v.busy  = (g != 4'b0000);
        v.dout  = o;
        return v;
    endfunction

    task automatic cmp(input string nm, input int vi, input logic [3:0] act, input logic [3:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got %b want %b", nm, vi, act, exp);
        end
    endtask

    task automatic check_pop();
        vec_t e;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard empty at vec %0d: got 0 entries want 1", n_vec);
        end else begin
            e = sb.pop_front();
            n_vec++;
            cmp("gnt",      n_vec, gnt_a[e.inst],          e.gnt);
            cmp("sel",      n_vec, {2'b00, sel_a[e.inst]}, {2'b00, e.sel});
            cmp("dout_vld", n_vec, {3'b000, vld_a[e.inst]},  {3'b000, e.vld});
            cmp("busy",     n_vec, {3'b000, busy_a[e.inst]}, {3'b000, e.busy});
            cmp("dout",     n_vec, {3'b000, dout_a[e.inst]}, {3'b000, e.dout});
        end
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        rst_a[v.inst] = v.rst_n;
        req_a[v.inst] = v.req;
        din_a[v.inst] = v.din;
        sb.push_back(v);
        @(posedge clk);
        #1;
        check_pop();
    endtask

    task automatic comb_chk(input logic [3:0] d, input logic exp);
        din_a[0] = d;
        #1;
        n_vec++;
        if (dout_a[0] !== exp) begin
            n_err++;
            $display("FAIL dout_comb din=%b: got %b want %b", d, dout_a[0], exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_a[i] = 1'b0;
            req_a[i] = 4'b0000;
            din_a[i] = 4'b0000;
        end

        // Reset held with all requests high, then first grant to requester 0.
        tbl.push_back(mk(0, 1'b0, 4'b1111, 4'b1111, 4'b0000, 2'd0, 1'b0));
        tbl.push_back(mk(0, 1'b0, 4'b1111, 4'b1111, 4'b0000, 2'd0, 1'b0));
        tbl.push_back(mk(0, 1'b1, 4'b1111, 4'b1111, 4'b0001, 2'd0, 1'b1));
        tbl.push_back(mk(0, 1'b1, 4'b1111, 4'b1110, 4'b0001, 2'd0, 1'b0));
        // Round robin between requesters 1 and 3, three-cycle tenures.
        tbl.push_back(mk(0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0));
        tbl.push_back(mk(0, 1'b1, 4'b1010, 4'b0010, 4'b0010, 2'd1, 1'b1));
        tbl.push_back(mk(0, 1'b1, 4'b1010, 4'b0000, 4'b0010, 2'd1, 1'b0));
        tbl.push_back(mk(0, 1'b1, 4'b1010, 4'b1101, 4'b0010, 2'd1, 1'b0));
        tbl.push_back(mk(0, 1'b1, 4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1));
        tbl.push_back(mk(0, 1'b1, 4'b1010, 4'b0111, 4'b1000, 2'd3, 1'b0));
        tbl.push_back(mk(0, 1'b1, 4'b1010, 4'b1010, 4'b1000, 2'd3, 1'b1));
        tbl.push_back(mk(0, 1'b1, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1));
        tbl.push_back(mk(0, 1'b1, 4'b1010, 4'b1000, 4'b0010, 2'd1, 1'b0));
        tbl.push_back(mk(0, 1'b1, 4'b1010, 4'b0010, 4'b0010, 2'd1, 1'b1));
        tbl.push_back(mk(0, 1'b1, 4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1));
        // Data path through owner 2; din[0] must not leak through.
        tbl.push_back(mk(0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0));
        tbl.push_back(mk(0, 1'b1, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1));
        tbl.push_back(mk(0, 1'b1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0));
        tbl.push_back(mk(0, 1'b1, 4'b0100, 4'b0001, 4'b0100, 2'd2, 1'b0));
        tbl.push_back(mk(0, 1'b1, 4'b0100, 4'b0101, 4'b0100, 2'd2, 1'b1));
        // Reset in the middle of owner 3's tenure, then requester 0 wins.
        tbl.push_back(mk(0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0));
        tbl.push_back(mk(0, 1'b1, 4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1));
        tbl.push_back(mk(0, 1'b1, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0));
        tbl.push_back(mk(0, 1'b1, 4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1));
        tbl.push_back(mk(0, 1'b0, 4'b1000, 4'b1000, 4'b0000, 2'd0, 1'b0));
        tbl.push_back(mk(0, 1'b1, 4'b1001, 4'b0001, 4'b0001, 2'd0, 1'b1));
        // Hold limit 4 with two constant requesters: 4 cycles each, alternating.
        tbl.push_back(mk(1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0));
        for (int c = 0; c < 16; c++) begin
            if (((c / 4) % 2) == 0) begin
                tbl.push_back(mk(1, 1'b1, 4'b0011, 4'b0010, 4'b0001, 2'd0, 1'b0));
            end else begin
                tbl.push_back(mk(1, 1'b1, 4'b0011, 4'b0010, 4'b0010, 2'd1, 1'b1));
            end
        end
        // Hold limit 2, sole requester keeps the path across expiries; once the
        // pointer has moved past it, a newcomer at index 0 takes over.
        tbl.push_back(mk(2, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0));
        for (int c = 0; c < 6; c++) begin
            tbl.push_back(mk(2, 1'b1, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1));
        end
        tbl.push_back(mk(2, 1'b1, 4'b0101, 4'b0100, 4'b0001, 2'd0, 1'b0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
        end

        // Combinational data path: dout tracks din[2] within the same cycle.
        drive(mk(0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0));
        drive(mk(0, 1'b1, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1));
        comb_chk(4'b0000, 1'b0);
        comb_chk(4'b0100, 1'b1);
        comb_chk(4'b1011, 1'b0);
        comb_chk(4'b0101, 1'b1);

        // A request pulse that falls before the edge is never seen.
        drive(mk(0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0));
        @(negedge clk);
        rst_a[0] = 1'b1;
        req_a[0] = 4'b0001;
        #2;
        req_a[0] = 4'b0000;
        @(posedge clk);
        #1;
        n_vec++;
        if (gnt_a[0] !== 4'b0000) begin
            n_err++;
            $display("FAIL short_pulse: got gnt %b want %b", gnt_a[0], 4'b0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux_arb4.md
# mux_arb4

Round-robin arbiter and select sequencer for the shared 1-bit 4:1 mux path. Four requesters each present a request and a 1-bit data line. The block grants one requester at a time and drives the 2-bit mux select. It forwards the granted requester's bit as a qualified output stream. A hold limit bounds how long any one requester can keep the path.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per tenure; legal range 1..255.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `req`  in  4  request per requester; `req[i]` high = requester i wants the path.
- `din`  in  4  data bit per requester; `din[i]` is requester i's bit.
- `gnt`  out  4  one-hot grant, registered; all-zero when idle.
- `sel`  out  2  mux select = index of granted requester, registered.
- `dout`  out  1  `din[sel]` when granted, else 0; combinational from `din`.
- `dout_vld`  out  1  high exactly when `gnt` is non-zero.
- `busy`  out  1  high in GRANT state.

## Operation
- States: IDLE and GRANT.
- Reset (`rst_n` low at an edge): state IDLE, `gnt`=0, `sel`=0, `dout_vld`=0, `busy`=0, `dout`=0, pointer `ptr`=0, hold counter `hcnt`=0.
- Priority: requesters are searched in order `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4). The first one with `req` high wins.
- IDLE -> GRANT when any `req` bit is high.
  - The winner is registered into `gnt` and `sel`.
  - `hcnt` is set to 1.
- GRANT, owner o, tenure continues while `req[o]`=1 and `hcnt` < `MAX_HOLD`. Each such cycle `hcnt` increments.
- GRANT, tenure ends when `req[o]`=0, or `hcnt`=`MAX_HOLD` at the edge.
  - `ptr` becomes o+1 mod 4.
  - Re-arbitration happens at the same edge using the new `ptr` and current `req`. There is no dead cycle.
  - If a winner exists, stay in GRANT with the new owner and set `hcnt`=1.
  - If no request is pending, go to IDLE and clear `gnt`.
- Hold expiry with the owner still requesting and no other requester: the owner is re-granted with `hcnt`=1, and `gnt` stays unchanged.
- Hold expiry with the owner still requesting and another requester pending: the other requester wins, because `ptr` has moved past the owner.
- `hcnt` is 8 bits wide and saturates. It never wraps, because `MAX_HOLD` ≤ 255.
- `ptr` advances only when a tenure ends, never in IDLE.
- A `req[i]` pulse shorter than one cycle between edges is not seen. Requests are sampled only at rising edges.

## Timing
- Grant latency: `req` seen high at edge k makes `gnt`/`sel` valid after edge k, i.e. one cycle.
- `dout` is combinational from `din` through the `sel`-driven mux. Zero-cycle data path; `din` may change every cycle during a tenure.
- Release latency: the owner drops `req` before edge k, and the next grant is visible after edge k.
- Maximum tenure is exactly `MAX_HOLD` cycles of `gnt[o]` high before handover, when competition exists.
- Reset mid-tenure: `gnt` and `dout_vld` are 0 after the reset edge, and `ptr` returns to 0. In-flight data is dropped with no handshake.
- `gnt`, `sel`, `busy`, and `dout_vld` are glitch-free registered outputs. `dout` is combinational.

## Structure
- Package `mux_arb_pkg`:
  - state enum {IDLE, GRANT};
  - constant `N_REQ`=4;
  - constant `SEL_W`=2;
  - constant `HCNT_W`=8.
- Sub-module `rr_pick4` (combinational):
  - inputs `req[3:0]` and `ptr[1:0]`;
  - outputs `found`, `idx[1:0]`, and one-hot `win[3:0]`.
- Top level contains the FSM, the `ptr`/`hcnt` registers, and the inline 4:1 output mux.

## Test plan
- Reset: hold `rst_n`=0 for 2 edges with `req`=4'b1111. Then all outputs are 0. Release, and one edge later `gnt`=4'b0001, `sel`=0.
- Round robin with `MAX_HOLD`=8: `req`=4'b1010 held, each owner releases after 3 cycles then re-requests. Grants alternate 4'b0010, 4'b1000, 4'b0010, each lasting 3 cycles with no gap.
- Hold limit with `MAX_HOLD`=4: `req`=4'b0011 held constantly. `gnt`=4'b0001 for exactly 4 cycles, then 4'b0010 for 4 cycles, repeating.
- Sole requester at expiry with `MAX_HOLD`=2: `req`=4'b0100 held for 6 cycles. `gnt` stays 4'b0100 continuously, `dout_vld`=1 throughout, and `ptr` ends at 3.
- Data path: grant owner 2 and drive `din`=4'b0100 then 4'b0000. `dout` follows 1 then 0 in the same cycles. `din[0]` toggling has no effect on `dout`.
- Reset mid-tenure: owner 3 at `hcnt`=3, then `rst_n`=0 for one edge. `gnt`=0 after that edge. With `req`=4'b1001 after release, the next grant is 4'b0001.
